// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and default geometry for the memory arbiter
package mem_arb_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 16;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: 2-way winner select; round-robin on ties, or fixed req0 priority with MEM_ARB_FIXED_PRI_EN
module mem_arb_pick (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last,
    output logic o_any,
    output logic o_sel
);
`ifdef MEM_ARB_FIXED_PRI_EN
    logic w_unused_last;
    assign w_unused_last = i_last;
    assign o_sel = !i_valid0;
`else
    // On a tie the requester not granted last wins; otherwise the lone requester wins
    assign o_sel = (i_valid0 && i_valid1) ? !i_last : !i_valid0;
`endif
    assign o_any = i_valid0 || i_valid1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester single-memory arbiter, IDLE->ACCESS->RESP; MEM_ARB_FIXED_PRI_EN selects fixed priority
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req0_valid_i,
    input  logic                  req0_wr_rd_en_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [WIDTH-1:0]      req0_wdata_i,
    output logic                  req0_ready_o,
    output logic [WIDTH-1:0]      req0_rdata_o,
    input  logic                  req1_valid_i,
    input  logic                  req1_wr_rd_en_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [WIDTH-1:0]      req1_wdata_i,
    output logic                  req1_ready_o,
    output logic [WIDTH-1:0]      req1_rdata_o,
    output logic                  mem_valid_o,
    output logic                  mem_wr_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    output logic                  busy_o
);
    state_e r_state;
    logic   r_sel;
    logic   w_any;
    logic   w_sel;
    logic   w_last;

    mem_arb_pick u_pick (
        .i_valid0 (req0_valid_i),
        .i_valid1 (req1_valid_i),
        .i_last   (w_last),
        .o_any    (w_any),
        .o_sel    (w_sel)
    );

`ifdef MEM_ARB_FIXED_PRI_EN
    assign w_last = 1'b0;
`else
    logic r_last;
    assign w_last = r_last;
    // Last-grant pointer moves only when a ready pulse is issued; reset favours req0
    always_ff @(posedge clk_i) begin
        if (!rst_i) r_last <= 1'b1;
        else if (r_state == ACCESS && mem_ready_i) r_last <= r_sel;
    end
`endif

    // Main FSM: latch the winner's request, wait for the memory ack, pulse ready, then a recovery cycle
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state        <= IDLE;
            r_sel          <= 1'b0;
            mem_valid_o    <= 1'b0;
            mem_wr_rd_en_o <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            req0_ready_o   <= 1'b0;
            req1_ready_o   <= 1'b0;
            req0_rdata_o   <= '0;
            req1_rdata_o   <= '0;
            busy_o         <= 1'b0;
        end else begin
            req0_ready_o <= 1'b0;
            req1_ready_o <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_sel          <= w_sel;
                    mem_valid_o    <= 1'b1;
                    mem_wr_rd_en_o <= w_sel ? req1_wr_rd_en_i : req0_wr_rd_en_i;
                    mem_addr_o     <= w_sel ? req1_addr_i : req0_addr_i;
                    mem_wdata_o    <= w_sel ? req1_wdata_i : req0_wdata_i;
                    busy_o         <= 1'b1;
                    r_state        <= ACCESS;
                end
                ACCESS: if (mem_ready_i) begin
                    mem_valid_o  <= 1'b0;
                    req0_ready_o <= !r_sel;
                    req1_ready_o <= r_sel;
                    if (!mem_wr_rd_en_o && !r_sel) req0_rdata_o <= mem_rdata_i;
                    if (!mem_wr_rd_en_o && r_sel) req1_rdata_o <= mem_rdata_i;
                    r_state      <= RESP;
                end
                default: begin
                    busy_o  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small registered memory model
module tb_mem_arbiter;
    localparam int W = 4;
    localparam int A = 4;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         req0_valid_i = 1'b0, req0_wr_rd_en_i = 1'b0;
    logic [A-1:0] req0_addr_i = '0;
    logic [W-1:0] req0_wdata_i = '0;
    logic         req0_ready_o;
    logic [W-1:0] req0_rdata_o;
    logic         req1_valid_i = 1'b0, req1_wr_rd_en_i = 1'b0;
    logic [A-1:0] req1_addr_i = '0;
    logic [W-1:0] req1_wdata_i = '0;
    logic         req1_ready_o;
    logic [W-1:0] req1_rdata_o;
    logic         mem_valid_o, mem_wr_rd_en_o;
    logic [A-1:0] mem_addr_o;
    logic [W-1:0] mem_wdata_o;
    logic         mem_ready_i = 1'b0;
    logic [W-1:0] mem_rdata_i = '0;
    logic         busy_o;

    logic [W-1:0] mem [16] = '{5: 4'h6, default: 4'h0};
    int           stall = 0;
    int           cnt = 0;
    int           checks = 0;
    int           errors = 0;
    logic [1:0]   who;

    mem_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_wr_rd_en_i(req0_wr_rd_en_i), .req0_addr_i(req0_addr_i),
        .req0_wdata_i(req0_wdata_i), .req0_ready_o(req0_ready_o), .req0_rdata_o(req0_rdata_o),
        .req1_valid_i(req1_valid_i), .req1_wr_rd_en_i(req1_wr_rd_en_i), .req1_addr_i(req1_addr_i),
        .req1_wdata_i(req1_wdata_i), .req1_ready_o(req1_ready_o), .req1_rdata_o(req1_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_wr_rd_en_o(mem_wr_rd_en_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Registered memory: acks after `stall` extra cycles, one-cycle ack pulse
    always @(posedge clk_i) begin
        if (mem_valid_o && !mem_ready_i && cnt >= stall) begin
            mem_ready_i <= 1'b1;
            mem_rdata_i <= mem[mem_addr_o];
            if (mem_wr_rd_en_o) mem[mem_addr_o] <= mem_wdata_o;
            cnt <= 0;
        end else begin
            mem_ready_i <= 1'b0;
            cnt <= (mem_valid_o && !mem_ready_i) ? cnt + 1 : 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic wait_ready(output logic [1:0] w);
        w = 2'b00;
        for (int i = 0; i < 30 && w == 2'b00; i++) begin
            @(negedge clk_i);
            w = {req1_ready_o, req0_ready_o};
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out"}, {mem_valid_o, mem_wr_rd_en_o, mem_addr_o, mem_wdata_o, req0_ready_o,
            req1_ready_o, req0_rdata_o, req1_rdata_o, busy_o}, 0);
    endtask

    initial begin
        step();
        step();
        chk_zero("reset");
        rst_i = 1'b1;
        step();

        // write then read by req0
        req0_valid_i = 1; req0_wr_rd_en_i = 1; req0_addr_i = 3; req0_wdata_i = 4'hA;
        step();
        chk("wr_issue", {busy_o, mem_valid_o, mem_wr_rd_en_o, mem_addr_o, mem_wdata_o}, {3'b111, 4'd3, 4'hA});
        step();
        chk("wr_early", req0_ready_o, 0);
        step();
        chk("wr_ready", req0_ready_o, 1);
        req0_valid_i = 0;
        step();
        chk("wr_resp", {req0_ready_o, busy_o}, 0);
        req0_valid_i = 1; req0_wr_rd_en_i = 0; req0_addr_i = 3;
        step();
        step();
        chk("rd_early", req0_ready_o, 0);
        step();
        chk("rd_ready", {req0_ready_o, req0_rdata_o}, {1'b1, 4'hA});
        req0_valid_i = 0;
        step();
        chk("rd_width", req0_ready_o, 0);

        // tie from reset
        do_reset();
        req0_valid_i = 1; req0_wr_rd_en_i = 0; req0_addr_i = 3;
        req1_valid_i = 1; req1_wr_rd_en_i = 0; req1_addr_i = 5;
        for (int k = 0; k < 4; k++) begin
            wait_ready(who);
`ifdef MEM_ARB_FIXED_PRI_EN
            chk("tie_grant", who, 2'b01);
`else
            chk("tie_grant", who, (k % 2 == 0) ? 2'b01 : 2'b10);
`endif
            chk("tie_rdata", who[1] ? req1_rdata_o : req0_rdata_o, who[1] ? 4'h6 : 4'hA);
            step();
            chk("tie_width", {req1_ready_o, req0_ready_o}, 0);
        end
        req0_valid_i = 0; req1_valid_i = 0;
        step();
        step();
        step();

        // memory stall, req0 alone
        stall = 5;
        req0_valid_i = 1; req0_wr_rd_en_i = 0; req0_addr_i = 3;
        step();
        chk("st_issue", {mem_valid_o, mem_addr_o}, {1'b1, 4'd3});
        for (int i = 0; i < 6; i++) begin
            step();
            chk("st_hold", {mem_valid_o, mem_wr_rd_en_o, mem_addr_o, req0_ready_o}, {1'b1, 1'b0, 4'd3, 1'b0});
        end
        step();
        chk("st_ready", {req0_ready_o, req0_rdata_o}, {1'b1, 4'hA});
        req0_valid_i = 0;
        step();
        step();

        // reset during ACCESS, then tie
        stall = 3;
        req1_valid_i = 1; req1_wr_rd_en_i = 0; req1_addr_i = 5;
        step();
        chk("ra_busy", busy_o, 1);
        step();
        rst_i = 0;
        step();
        chk_zero("ra_reset");
        rst_i = 1;
        req1_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ra_quiet", {req0_ready_o, req1_ready_o, busy_o}, 0);
        end
        stall = 0;
        req0_valid_i = 1; req0_wr_rd_en_i = 0; req0_addr_i = 3;
        req1_valid_i = 1; req1_wr_rd_en_i = 0; req1_addr_i = 5;
        wait_ready(who);
        chk("ra_tie", who, 2'b01);
        req0_valid_i = 0; req1_valid_i = 0;
        step();
        step();

        // write isolation: req1 writes addr 5 while req0 waits to read addr 5
        req0_valid_i = 1; req0_wr_rd_en_i = 0; req0_addr_i = 5;
        req1_valid_i = 1; req1_wr_rd_en_i = 1; req1_addr_i = 5; req1_wdata_i = 4'h3;
`ifdef MEM_ARB_FIXED_PRI_EN
        wait_ready(who);
        chk("iso_first", who, 2'b01);
        chk("iso_rdata", req0_rdata_o, 4'h6);
        req0_valid_i = 0;
        wait_ready(who);
        chk("iso_second", who, 2'b10);
        req1_valid_i = 0;
`else
        who = 2'b00;
        for (int i = 0; i < 10 && !who[1]; i++) begin
            step();
            chk("iso_rdy", req0_ready_o, 0);
            chk("iso_hold", req0_rdata_o, 4'hA);
            who[1] = req1_ready_o;
        end
        chk("iso_wr_done", who[1], 1);
        req1_valid_i = 0;
        wait_ready(who);
        chk("iso_grant", who, 2'b01);
        chk("iso_rdata", req0_rdata_o, 4'h3);
        req0_valid_i = 0;
`endif
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
